// File: rtl/fp_compare_vec_if.sv
// fp_compare_vec_if: operand beat and result handshake bus.
// master = upstream/downstream driver, slave = comparator.
interface fp_compare_vec_if #(
    parameter int WE  = 11,
    parameter int WF  = 22,
    parameter int NCH = 3
);
    localparam int W = WE + WF + 3;

    logic             in_valid;
    logic             in_ready;
    logic [NCH*W-1:0] in_a;
    logic [NCH*W-1:0] in_b;
    logic [NCH*3-1:0] in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [NCH-1:0]   out_flag;
    logic [NCH*W-1:0] out_val;
    logic [NCH-1:0]   out_unord;
    logic             nan_clr;
    logic [NCH-1:0]   nan_seen;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready, nan_clr,
        input  in_ready, out_valid, out_flag, out_val, out_unord,
        input  nan_seen
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready, nan_clr,
        output in_ready, out_valid, out_flag, out_val, out_unord,
        output nan_seen
    );
endinterface

// File: rtl/fp_compare_vec.sv
// fp_compare_vec: 2-stage multi-channel FloPoCo compare/min/max.
// Sticky per-channel NaN status enabled by FPCMP_STICKY_NAN_EN.
module fp_compare_vec #(
    parameter int WE  = 11,
    parameter int WF  = 22,
    parameter int NCH = 3
) (
    input logic             clk,
    input logic             rst,
    fp_compare_vec_if.slave bus
);
    localparam int W  = WE + WF + 3;
    localparam int KW = WE + WF + 2;

    logic             adv;
    logic             s1_v;
    logic [NCH-1:0]   d_anan, d_bnan, d_lt, d_eq, d_zz, d_sa, d_sb;
    logic [NCH-1:0]   s1_anan, s1_bnan, s1_lt, s1_eq, s1_zz;
    logic [NCH-1:0]   s1_sa, s1_sb;
    logic [NCH*W-1:0] s1_a, s1_b;
    logic [NCH*3-1:0] s1_mode;
    logic [NCH-1:0]   nx_flag, nx_unord;
    logic [NCH*W-1:0] nx_val;
    logic             out_v;
    logic [NCH-1:0]   o_flag, o_unord;
    logic [NCH*W-1:0] o_val;

    assign adv           = !out_v || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_v;
    assign bus.out_flag  = o_flag;
    assign bus.out_val   = o_val;
    assign bus.out_unord = o_unord;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [W-1:0]  a, b;
        logic [KW-1:0] ka, kb;
        logic [2:0]    m;
        logic          un, lt, eq, gt, selb, flag;
        logic [W-1:0]  val;

        assign a = bus.in_a[c*W +: W];
        assign b = bus.in_b[c*W +: W];

        // zero and inf carry no payload: blank exp/frac in the key
        assign ka = a[W-2] ? {a[W-1:W-2], a[WE+WF-1:0]}
                           : {a[W-1:W-2], {(WE+WF){1'b0}}};
        assign kb = b[W-2] ? {b[W-1:W-2], b[WE+WF-1:0]}
                           : {b[W-1:W-2], {(WE+WF){1'b0}}};

        assign d_anan[c] = &a[W-1:W-2];
        assign d_bnan[c] = &b[W-1:W-2];
        assign d_lt[c]   = ka < kb;
        assign d_eq[c]   = ka == kb;
        assign d_zz[c]   = (ka == '0) && (kb == '0);
        assign d_sa[c]   = a[W-3];
        assign d_sb[c]   = b[W-3];

        always_comb begin
            m    = s1_mode[c*3 +: 3];
            un   = s1_anan[c] || s1_bnan[c];
            lt   = 1'b0;
            eq   = 1'b0;
            flag = 1'b0;
            val  = '0;
            if (s1_zz[c]) begin
                eq = 1'b1;
            end else if (s1_sa[c] != s1_sb[c]) begin
                lt = s1_sa[c];
            end else if (!s1_sa[c]) begin
                lt = s1_lt[c];
                eq = s1_eq[c];
            end else begin
                lt = !s1_lt[c] && !s1_eq[c];
                eq = s1_eq[c];
            end
            gt   = !lt && !eq;
            // MIN takes B when A > B, MAX when A < B; NaN A is kept
            selb = un ? !s1_anan[c] : (m[0] ? lt : gt);
            unique case (m)
                3'b000:  flag = !un && lt;
                3'b001:  flag = !un && (lt || eq);
                3'b010:  flag = !un && gt;
                3'b011:  flag = !un && (gt || eq);
                3'b100:  flag = !un && eq;
                3'b101:  flag = un || !eq;
                default: begin
                    flag = selb;
                    val  = selb ? s1_b[c*W +: W] : s1_a[c*W +: W];
                end
            endcase
        end

        assign nx_flag[c]         = flag;
        assign nx_unord[c]        = un;
        assign nx_val[c*W +: W]   = val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v    <= 1'b0;
            s1_anan <= '0;
            s1_bnan <= '0;
            s1_lt   <= '0;
            s1_eq   <= '0;
            s1_zz   <= '0;
            s1_sa   <= '0;
            s1_sb   <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_mode <= '0;
            out_v   <= 1'b0;
            o_flag  <= '0;
            o_val   <= '0;
            o_unord <= '0;
        end else if (adv) begin
            s1_v    <= bus.in_valid;
            s1_anan <= d_anan;
            s1_bnan <= d_bnan;
            s1_lt   <= d_lt;
            s1_eq   <= d_eq;
            s1_zz   <= d_zz;
            s1_sa   <= d_sa;
            s1_sb   <= d_sb;
            s1_a    <= bus.in_a;
            s1_b    <= bus.in_b;
            s1_mode <= bus.in_mode;
            out_v   <= s1_v;
            o_flag  <= nx_flag;
            o_val   <= nx_val;
            o_unord <= nx_unord;
        end
    end

`ifdef FPCMP_STICKY_NAN_EN
    logic [NCH-1:0] seen;

    // set wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen <= '0;
        end else begin
            seen <= (seen & ~{NCH{bus.nan_clr}})
                  | ({NCH{out_v && bus.out_ready}} & o_unord);
        end
    end

    assign bus.nan_seen = seen;
`else
    logic unused_clr;
    assign unused_clr   = bus.nan_clr;
    assign bus.nan_seen = '0;
`endif
endmodule

// File: tb/tb_fp_compare_vec.sv
// tb_fp_compare_vec: directed vector table plus stall, sticky
// and mid-stream reset sequences for fp_compare_vec.
module tb_fp_compare_vec;
    localparam int WE  = 11;
    localparam int WF  = 22;
    localparam int NCH = 3;
    localparam int W   = WE + WF + 3;
    localparam int NV  = 8;

    localparam logic [35:0] ONE  = 36'h4FFC00000;
    localparam logic [35:0] TWO  = 36'h500000000;
    localparam logic [35:0] NONE = 36'h6FFC00000;
    localparam logic [35:0] PZ   = 36'h000000000;
    localparam logic [35:0] NZ   = 36'h200000000;
    localparam logic [35:0] PINF = 36'h800000000;
    localparam logic [35:0] NINF = 36'hA00000000;
    localparam logic [35:0] FNAN = 36'hC00000000;

    localparam logic [2:0] LT  = 3'd0;
    localparam logic [2:0] LE  = 3'd1;
    localparam logic [2:0] GT  = 3'd2;
    localparam logic [2:0] GE  = 3'd3;
    localparam logic [2:0] EQ  = 3'd4;
    localparam logic [2:0] NE  = 3'd5;
    localparam logic [2:0] MIN = 3'd6;
    localparam logic [2:0] MAX = 3'd7;

`ifdef FPCMP_STICKY_NAN_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct packed {
        logic [NCH*W-1:0] a;
        logic [NCH*W-1:0] b;
        logic [NCH*3-1:0] mode;
        logic [NCH-1:0]   flag;
        logic [NCH*W-1:0] val;
        logic [NCH-1:0]   unord;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t tbl[NV];

    fp_compare_vec_if #(.WE(WE), .WF(WF), .NCH(NCH)) bus ();

    fp_compare_vec #(.WE(WE), .WF(WF), .NCH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [35:0] beat(input int k);
        logic [35:0] r;
        r = {2'b01, 1'b0, 11'(k + 1), 22'(k)};
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_mode  = v.mode;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_lat1"}, bus.out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_flag"}, bus.out_flag, v.flag);
        chk({tag, "_val"}, bus.out_val, v.val);
        chk({tag, "_unord"}, bus.out_unord, v.unord);
    endtask

    initial begin
        int   sent, rx, cyc;
        bit   acc, pstall;
        logic [NCH*W-1:0] pval;
        logic [NCH-1:0]   pflag;

        tests = 0;
        fails = 0;

        tbl[0].a = {ONE, ONE, ONE};   tbl[0].b = {TWO, TWO, TWO};
        tbl[0].mode = {GT, LE, LT};   tbl[0].flag = 3'b011;
        tbl[0].val = '0;              tbl[0].unord = 3'b000;

        tbl[1].a = {PZ, PZ, PZ};      tbl[1].b = {NZ, NZ, NZ};
        tbl[1].mode = {NE, MIN, EQ};  tbl[1].flag = 3'b001;
        tbl[1].val = '0;              tbl[1].unord = 3'b000;

        tbl[2].a = {NINF, PINF, NONE}; tbl[2].b = {NONE, TWO, ONE};
        tbl[2].mode = {GE, MAX, LT};   tbl[2].flag = 3'b001;
        tbl[2].val = {PZ, PINF, PZ};   tbl[2].unord = 3'b000;

        tbl[3].a = {FNAN, FNAN, FNAN}; tbl[3].b = {ONE, ONE, ONE};
        tbl[3].mode = {MIN, NE, LT};   tbl[3].flag = 3'b010;
        tbl[3].val = {FNAN, PZ, PZ};   tbl[3].unord = 3'b111;

        tbl[4].a = {TWO, TWO, ONE};    tbl[4].b = {ONE, ONE, FNAN};
        tbl[4].mode = {MIN, MAX, MIN}; tbl[4].flag = 3'b101;
        tbl[4].val = {ONE, TWO, FNAN}; tbl[4].unord = 3'b001;

        tbl[5].a = {NONE, NINF, NONE}; tbl[5].b = {NINF, NONE, NZ};
        tbl[5].mode = {MAX, LT, GT};   tbl[5].flag = 3'b010;
        tbl[5].val = {NONE, PZ, PZ};   tbl[5].unord = 3'b000;

        tbl[6].a = {FNAN, NZ, PINF};   tbl[6].b = {FNAN, PZ, PINF};
        tbl[6].mode = {EQ, MAX, LE};   tbl[6].flag = 3'b001;
        tbl[6].val = {PZ, NZ, PZ};     tbl[6].unord = 3'b100;

        tbl[7].a = {NONE, TWO, ONE};   tbl[7].b = {ONE, ONE, TWO};
        tbl[7].mode = {MIN, GE, NE};   tbl[7].flag = 3'b011;
        tbl[7].val = {NONE, PZ, PZ};   tbl[7].unord = 3'b000;

        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_mode = '0;
        bus.out_ready = 1'b1;
        bus.nan_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_flag", bus.out_flag, 0);
        chk("rst_out_val", bus.out_val, 0);
        chk("rst_out_unord", bus.out_unord, 0);
        chk("rst_nan_seen", bus.nan_seen, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < NV; i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        @(negedge clk);
        chk("sticky_set", bus.nan_seen, STICKY ? 3'b111 : 3'b000);
        bus.nan_clr = 1'b1;
        @(negedge clk);
        bus.nan_clr = 1'b0;
        chk("sticky_clr", bus.nan_seen, 0);
        run_vec(tbl[4], "v4b");
        bus.nan_clr = 1'b1;
        @(negedge clk);
        bus.nan_clr = 1'b0;
        chk("sticky_set_wins", bus.nan_seen, STICKY ? 3'b001 : 3'b000);

        // 5-beat stream with out_ready low on cycles 3..6
        bus.in_a = {3{beat(0)}};
        bus.in_b = '0;
        bus.in_mode = {3{MAX}};
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        acc = bus.in_valid && bus.in_ready;
        sent = 0;
        rx = 0;
        cyc = 0;
        pstall = 1'b0;
        pval = '0;
        pflag = '0;
        while (rx < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 5) bus.in_a = {3{beat(sent)}};
                else bus.in_valid = 1'b0;
            end
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (pstall) begin
                chk($sformatf("hold_valid_c%0d", cyc), bus.out_valid, 1);
                chk($sformatf("hold_val_c%0d", cyc), bus.out_val, pval);
                chk($sformatf("hold_flag_c%0d", cyc), bus.out_flag, pflag);
            end
            if (bus.out_valid && !bus.out_ready)
                chk($sformatf("stall_in_ready_c%0d", cyc), bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("stream_val%0d", rx), bus.out_val,
                    {3{beat(rx)}});
                chk($sformatf("stream_flag%0d", rx), bus.out_flag, 0);
                rx++;
            end
            pstall = bus.out_valid && !bus.out_ready;
            pval = bus.out_val;
            pflag = bus.out_flag;
            acc = bus.in_valid && bus.in_ready;
        end
        chk("stream_count", rx, 5);
        chk("stream_sent", sent, 5);
        repeat (3) begin
            @(negedge clk);
            chk("stream_no_dup", bus.out_valid, 0);
        end

        // reset with two beats in flight
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_a = {3{TWO}};
        bus.in_b = {3{ONE}};
        bus.in_mode = {3{GT}};
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_a = {3{ONE}};
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("inflight_valid", bus.out_valid, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_flag", bus.out_flag, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle%0d", k), bus.out_valid, 0);
        end
        chk("post_rst_in_ready", bus.in_ready, 1);
        run_vec(tbl[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
